uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
- UART receiver: the receive-side counterpart of the team's UART transmitter.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).
- Samples the serial line at mid-bit using an internal baud counter and an internal bit counter.
- Presents the received byte with a one-cycle done strobe plus parity and framing status, feeding the UART_Tx_Rx top level / loopback path.

Parameters:
- BIT_TICKS, 5208, clk cycles per bit (50 MHz / 9600 baud); minimum 4.
- PARITY_ODD, 0, 0 = even parity expected; 1 = odd parity expected.
- CNT_W, 16, baud counter width; must satisfy 2^CNT_W > BIT_TICKS.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_i  in  1  serial input, asynchronous to clk, idle high.
- rx_data  out  8  last received byte; held until the next completed frame.
- rx_done  out  1  single-cycle pulse when a frame completes (good or bad).
- parity_err  out  1  parity mismatch of the last completed frame.
- frame_err  out  1  stop bit sampled 0 in the last completed frame.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1, asynchronous):
  - State=IDLE; baud counter, bit counter and shift register = 0.
  - Both synchronizer flops and the edge-detect flop = 1.
  - rx_data=8'h00; rx_done=0; parity_err=0; frame_err=0; busy=0.
- Input conditioning:
  - rx_i passes through a 2-flop synchronizer giving rx_s.
  - rx_s_d is rx_s delayed one cycle.
  - Falling edge = rx_s_d & ~rx_s.
- States: IDLE, START, DATA, PARITY, STOP. Registered next-state logic. Outputs are registered.
- IDLE:
  - On a falling edge, go to START and clear the baud counter.
  - A line held low (break) does not retrigger; a new rising then falling edge is required.
- START:
  - Baud counter increments every clk.
  - At count == BIT_TICKS/2 - 1 (integer division), sample rx_s.
  - If rx_s = 0: go to DATA, clear the baud counter and the bit counter.
  - If rx_s = 1: glitch. Return to IDLE; no rx_done, no flag change.
- DATA:
  - At count == BIT_TICKS-1, sample rx_s, shift it into the shift register MSB-side (shift right), clear the baud counter, and increment the bit counter.
  - After the 8th sample (bit counter wraps 7->0), go to PARITY.
- PARITY:
  - At count == BIT_TICKS-1, sample parity bit p and clear the baud counter.
  - perr = (^shift ^ p ^ PARITY_ODD) != 0.
  - Go to STOP.
- STOP:
  - At count == BIT_TICKS-1, sample the stop bit. On the same edge:
    - rx_data <= shift register.
    - parity_err <= perr.
    - frame_err <= ~stop_sample.
    - rx_done <= 1.
    - Go to IDLE.
  - rx_data is updated even on error.
- rx_done timing: high for exactly one cycle, the cycle after the stop sample edge. It is cleared by default on every other cycle.
- Error flags and rx_data hold until the next rx_done.
- busy = (state != IDLE), registered with the state.
- Sampling points: mid-bit for every bit, since all post-start bits sample a full BIT_TICKS after the mid-start sample.
- Back-to-back frames: a start edge arriving in the cycle after the STOP sample is detected normally, because IDLE is entered the same edge.
- Frame error with line still low: enter IDLE and wait for line high, then a falling edge.
- rst mid-frame: the frame is abandoned immediately. No rx_done; rx_data and flags reset to 0.
- Counters never wrap inside a state: each state transition clears the baud counter.

Test Plan:
- BIT_TICKS=16, PARITY_ODD=0; send 0xA5 (bits 1,0,1,0,0,1,0,1; parity 0; stop 1) -> one rx_done pulse; rx_data=8'hA5, parity_err=0, frame_err=0; busy low after pulse.
- Glitch: rx_i low for 4 clks then high -> START rejects at tick 7; state returns to IDLE; no rx_done; rx_data unchanged.
- Parity error: send 0x03 with parity bit 1 -> rx_data=8'h03, parity_err=1, frame_err=0. Next good frame 0x55 (parity 0) -> parity_err clears to 0.
- Framing error: send 0x3C with stop bit 0, then hold low 40 clks, then high -> rx_data=8'h3C, frame_err=1, exactly one rx_done. No new frame until line goes high then low.
- Back-to-back: frames 0x00 then 0xFF with no idle gap (PARITY_ODD=1: parity bits 1 then 1) -> two rx_done pulses 11*16 clks apart; both with parity_err=0.
- Reset mid-frame: assert rst during DATA bit 4 of 0x81 -> outputs immediately 0, busy=0, no rx_done. After release, frame 0x81 (parity 0) -> rx_data=8'h81.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit. Each bit is
// sampled at mid-bit. Results are presented with a one-cycle rx_done strobe.
module uart_rx_fsm #(
  parameter int BIT_TICKS  = 5208,
  parameter bit PARITY_ODD = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_TICKS/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_TICKS - 1);

  state_e           state_q;
  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             perr_q;
  logic             fall, baud_end;

  assign fall     = rx_prev_q & ~rx_s_q;
  assign baud_end = (baud_q == FULL_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      rx_data    <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      rx_done   <= 1'b0;
      case (state_q)
        IDLE: begin
          // Edge-triggered, so a line held low after a frame cannot retrigger.
          if (fall) begin
            state_q <= START;
            busy    <= 1'b1;
            baud_q  <= '0;
          end
        end
        START: begin
          if (baud_q == HALF_M1) begin
            baud_q <= '0;
            if (!rx_s_q) begin
              state_q <= DATA;
              bit_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q  <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= PARITY;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        PARITY: begin
          if (baud_end) begin
            baud_q  <= '0;
            perr_q  <= ^shift_q ^ rx_s_q ^ PARITY_ODD;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q     <= '0;
            rx_data    <= shift_q;
            parity_err <= perr_q;
            frame_err  <= ~rx_s_q;
            rx_done    <= 1'b1;
            state_q    <= IDLE;
            busy       <= 1'b0;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm at 16 clocks per bit. One even-parity receiver and
// one odd-parity receiver listen to the same serial line.
module tb_uart_rx_fsm;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_i = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] e_data, o_data;
  logic e_done, e_perr, e_ferr, e_busy;
  logic o_done, o_perr, o_ferr, o_busy;

  uart_rx_fsm #(.BIT_TICKS(T), .PARITY_ODD(1'b0), .CNT_W(16)) u_even (
    .clk(clk), .rst(rst), .rx_i(rx_i), .rx_data(e_data), .rx_done(e_done),
    .parity_err(e_perr), .frame_err(e_ferr), .busy(e_busy));

  uart_rx_fsm #(.BIT_TICKS(T), .PARITY_ODD(1'b1), .CNT_W(16)) u_odd (
    .clk(clk), .rst(rst), .rx_i(rx_i), .rx_data(o_data), .rx_done(o_done),
    .parity_err(o_perr), .frame_err(o_ferr), .busy(o_busy));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Count rx_done-high cycles, so a stretched pulse counts more than once.
  int e_cnt = 0;
  always @(negedge clk) if (e_done) e_cnt <= e_cnt + 1;

  int o_cnt = 0, o_t_prev = 0, o_t_last = 0;
  logic [7:0] o_d_prev = '0, o_d_last = '0;
  logic o_perr_prev = 1'b0, o_perr_last = 1'b0, o_ferr_last = 1'b0;
  always @(negedge clk) if (o_done) begin
    o_cnt       <= o_cnt + 1;
    o_t_prev    <= o_t_last;
    o_t_last    <= cyc;
    o_d_prev    <= o_d_last;
    o_d_last    <= o_data;
    o_perr_prev <= o_perr_last;
    o_perr_last <= o_perr;
    o_ferr_last <= o_ferr;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (T) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(e_data), 32'h00);
    chk("rst_done", 32'(e_done), 0);
    chk("rst_perr", 32'(e_perr), 0);
    chk("rst_ferr", 32'(e_ferr), 0);
    chk("rst_busy", 32'(e_busy), 0);
    rst = 1'b0;
    idle(5);

    // 0xA5, even parity bit 0
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(4);
    chk("a5_cnt", 32'(e_cnt), 1);
    chk("a5_data", 32'(e_data), 32'hA5);
    chk("a5_perr", 32'(e_perr), 0);
    chk("a5_ferr", 32'(e_ferr), 0);
    chk("a5_busy", 32'(e_busy), 0);
    chk("a5_odd_perr", 32'(o_perr), 1);

    // 4-clock low glitch: enters START, rejected at the half-bit sample
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("gl_busy_hi", 32'(e_busy), 1);
    idle(30);
    chk("gl_cnt", 32'(e_cnt), 1);
    chk("gl_busy_lo", 32'(e_busy), 0);
    chk("gl_data", 32'(e_data), 32'hA5);
    chk("gl_perr", 32'(e_perr), 0);

    // parity error, then cleared by a good frame
    send_frame(8'h03, 1'b1, 1'b1);
    idle(4);
    chk("pe_cnt", 32'(e_cnt), 2);
    chk("pe_data", 32'(e_data), 32'h03);
    chk("pe_perr", 32'(e_perr), 1);
    chk("pe_ferr", 32'(e_ferr), 0);
    send_frame(8'h55, 1'b0, 1'b1);
    idle(4);
    chk("p55_cnt", 32'(e_cnt), 3);
    chk("p55_data", 32'(e_data), 32'h55);
    chk("p55_perr", 32'(e_perr), 0);

    // framing error with the line held low afterwards
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("fe_cnt", 32'(e_cnt), 4);
    chk("fe_data", 32'(e_data), 32'h3C);
    chk("fe_ferr", 32'(e_ferr), 1);
    chk("fe_perr", 32'(e_perr), 0);
    chk("fe_busy_low", 32'(e_busy), 0);
    idle(30);
    chk("fe_busy_high", 32'(e_busy), 0);
    chk("fe_cnt_after", 32'(e_cnt), 4);

    // back-to-back frames, odd parity receiver
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(4);
    chk("bb_odd_cnt", 32'(o_cnt), 6);
    chk("bb_gap", 32'(o_t_last - o_t_prev), 11 * T);
    chk("bb_d0", 32'(o_d_prev), 32'h00);
    chk("bb_d1", 32'(o_d_last), 32'hFF);
    chk("bb_perr0", 32'(o_perr_prev), 0);
    chk("bb_perr1", 32'(o_perr_last), 0);
    chk("bb_ferr1", 32'(o_ferr_last), 0);
    chk("bb_even_cnt", 32'(e_cnt), 6);
    chk("bb_even_perr", 32'(e_perr), 1);

    // reset during data bit 4 of 0x81
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    rx_i = 1'b0;
    repeat (T / 2) @(negedge clk);
    chk("mr_busy_pre", 32'(e_busy), 1);
    rst = 1'b1;
    #1;
    chk("mr_data", 32'(e_data), 32'h00);
    chk("mr_done", 32'(e_done), 0);
    chk("mr_perr", 32'(e_perr), 0);
    chk("mr_ferr", 32'(e_ferr), 0);
    chk("mr_busy", 32'(e_busy), 0);
    @(negedge clk);
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(20);
    chk("mr_cnt", 32'(e_cnt), 6);
    send_frame(8'h81, 1'b0, 1'b1);
    idle(4);
    chk("r81_cnt", 32'(e_cnt), 7);
    chk("r81_data", 32'(e_data), 32'h81);
    chk("r81_perr", 32'(e_perr), 0);
    chk("r81_ferr", 32'(e_ferr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
